// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: frame geometry,
// receive FSM states and command encodings.
package spi_pkg;

  localparam int DATA_W = 10;
  localparam int HDR_W  = 3;
  localparam int SH_W   = DATA_W - HDR_W;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_SS = 2'd2
  } rx_state_t;

  // Command encodings on b9..b8
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_t;

endpackage

// File: rtl/spi_rx_hold.sv
// Valid/ready holding register for received words;
// a new word always wins and flags overrun if the old one was unread.
module spi_rx_hold
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              overrun
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= load && valid && !ready;
      if (load) begin
        data  <= word;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_rx_deser.sv
// SPI slave receive deserializer: merges upstream header
// bits with the serial payload into one parallel word.
module spi_rx_deser
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss_n,
  input  logic              mosi,
  input  logic              dser_en,
  input  logic [HDR_W-1:0]  hdr,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SH_W - 1);

  rx_state_t         state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [SH_W-2:0]   shreg, shreg_n;
  logic [HDR_W-1:0]  hdr_q, hdr_n;
  logic              load;
  logic              abort;
  logic [DATA_W-1:0] word;

  // b0 is taken straight from mosi on the completing edge
  assign word = {hdr_q, shreg, mosi};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      hdr_q     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      hdr_q     <= hdr_n;
      frame_err <= abort;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    hdr_n   = hdr_q;
    load    = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!ss_n && dser_en) begin
          state_n = SHIFT;
          shreg_n = {{(SH_W-2){1'b0}}, mosi};
          cnt_n   = CNT_W'(1);
          hdr_n   = hdr;
        end
      end
      SHIFT: begin
        if (ss_n || !dser_en) begin
          abort   = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
          shreg_n = '0;
        end else if (cnt == CNT_LAST) begin
          load    = 1'b1;
          state_n = WAIT_SS;
          cnt_n   = '0;
          shreg_n = '0;
        end else begin
          shreg_n = {shreg[SH_W-3:0], mosi};
          cnt_n   = cnt + CNT_W'(1);
        end
      end
      WAIT_SS: begin
        if (ss_n) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  spi_rx_hold u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .word    (word),
    .ready   (rx_ready),
    .data    (rx_data),
    .valid   (rx_valid),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_spi_rx_deser.sv
// Directed bench for spi_rx_deser: frames, abort,
// overrun, accept-on-completion and async reset.
module tb_spi_rx_deser;

  logic       clk;
  logic       rst_n;
  logic       ss_n;
  logic       mosi;
  logic       dser_en;
  logic [2:0] hdr;
  logic       rx_ready;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int vecs;
  int errs;

  spi_rx_deser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .dser_en   (dser_en),
    .hdr       (hdr),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk10(input string tag, input logic [9:0] obs,
                       input logic [9:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive n payload bits MSB first; rdy_last is rx_ready on the last edge
  task automatic frame(input logic [2:0] h, input logic [6:0] p,
                       input int n, input logic rdy_last);
    ss_n     = 1'b0;
    dser_en  = 1'b1;
    hdr      = h;
    rx_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      mosi = p[6-i];
      if (i == n - 1) rx_ready = rdy_last;
      step();
    end
  endtask

  task automatic end_frame();
    ss_n    = 1'b1;
    dser_en = 1'b0;
    step();
  endtask

  initial begin
    vecs     = 0;
    errs     = 0;
    rst_n    = 1'b0;
    ss_n     = 1'b1;
    mosi     = 1'b0;
    dser_en  = 1'b0;
    hdr      = 3'b000;
    rx_ready = 1'b0;
    step();
    step();
    chk10("rst_data", rx_data, 10'h000);
    chk1("rst_valid", rx_valid, 1'b0);
    chk1("rst_ferr", frame_err, 1'b0);
    chk1("rst_ovr", overrun, 1'b0);
    rst_n = 1'b1;
    step();

    // write-address style frame, accepted right away
    frame(3'b001, 7'b0100101, 7, 1'b1);
    chk10("a_data", rx_data, 10'h0A5);
    chk1("a_valid", rx_valid, 1'b1);
    chk1("a_ovr", overrun, 1'b0);
    end_frame();
    chk1("a_valid_drop", rx_valid, 1'b0);

    // read-data frame held while downstream stalls
    frame(3'b111, 7'h7F, 7, 1'b0);
    chk10("b_data", rx_data, 10'h3FF);
    chk1("b_valid", rx_valid, 1'b1);
    end_frame();
    for (int i = 0; i < 4; i++) step();
    chk1("b_hold_valid", rx_valid, 1'b1);
    chk10("b_hold_data", rx_data, 10'h3FF);
    chk1("b_no_ovr", overrun, 1'b0);
    rx_ready = 1'b1;
    step();
    chk1("b_accept", rx_valid, 1'b0);
    rx_ready = 1'b0;

    // abort after 4 payload bits
    frame(3'b000, 7'b1011011, 4, 1'b0);
    chk1("c_ferr_pre", frame_err, 1'b0);
    end_frame();
    chk1("c_ferr", frame_err, 1'b1);
    chk1("c_valid", rx_valid, 1'b0);
    step();
    chk1("c_ferr_pulse", frame_err, 1'b0);
    frame(3'b001, 7'h00, 7, 1'b0);
    chk10("c_next_data", rx_data, 10'h080);
    chk1("c_next_valid", rx_valid, 1'b1);
    end_frame();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk1("c_consumed", rx_valid, 1'b0);

    // overrun: unread word overwritten
    frame(3'b001, 7'b0100101, 7, 1'b0);
    end_frame();
    chk10("d_first", rx_data, 10'h0A5);
    frame(3'b010, 7'h33, 7, 1'b0);
    chk1("d_ovr", overrun, 1'b1);
    chk10("d_data", rx_data, 10'h133);
    chk1("d_valid", rx_valid, 1'b1);
    end_frame();
    chk1("d_ovr_pulse", overrun, 1'b0);
    chk1("d_valid_hold", rx_valid, 1'b1);

    // completion on the same edge as acceptance
    frame(3'b111, 7'h00, 7, 1'b1);
    chk1("e_no_ovr", overrun, 1'b0);
    chk10("e_data", rx_data, 10'h380);
    chk1("e_valid", rx_valid, 1'b1);
    rx_ready = 1'b0;
    end_frame();

    // async reset mid-frame after 3 payload bits
    frame(3'b101, 7'b1111111, 3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk10("f_rst_data", rx_data, 10'h000);
    chk1("f_rst_valid", rx_valid, 1'b0);
    chk1("f_rst_ferr", frame_err, 1'b0);
    chk1("f_rst_ovr", overrun, 1'b0);
    ss_n    = 1'b1;
    dser_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    frame(3'b000, 7'h2A, 7, 1'b1);
    chk10("f_data", rx_data, 10'h02A);
    chk1("f_valid", rx_valid, 1'b1);
    chk1("f_ferr", frame_err, 1'b0);
    end_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
